watchdog_reset: RTL and testbench
=================================

Name: watchdog_reset

Overview:
Watchdog timer that generates the active-low reset request feeding the system reset counter's reset_i input. Firmware or a JTAG-side agent must kick it periodically. If the kick stops, it drives a fixed-length low pulse on nreset_req_o, which restarts the reset countdown. It also keeps sticky cause and statistics for post-reset diagnosis.

Parameters:
CNT_W, 16, width of the timeout down-counter
TIMEOUT, 50000, reload value in clk_i cycles; legal range 1..2^CNT_W-1
WARN, 1000, early-warning threshold; must be < TIMEOUT
PULSE_LEN, 32, reset-request low time in cycles; legal range 1..255

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  watchdog enable (level)
kick_i  in  1  single-cycle kick; reloads the timer
cause_clr_i  in  1  clears fired_o and fire_count_o
nreset_req_o  out  1  active-low reset request to the reset counter
warn_o  out  1  high while armed and count <= WARN
fired_o  out  1  sticky: the watchdog has fired since the last clear
fire_count_o  out  8  number of fires, saturating at 255
count_o  out  CNT_W  current timeout count

Behaviour:
- All outputs are registered, except warn_o, which decodes only registered state.
- Reset: reset_i high sets, asynchronously:
  - state=DISABLED, count=TIMEOUT, pulse counter=0
  - nreset_req_o=1, fired_o=0, fire_count_o=0; warn_o is therefore 0
- DISABLED:
  - count is held at TIMEOUT.
  - enable_i=1 -> ARMED on the next edge, with count=TIMEOUT.
- ARMED, evaluated in this priority order each edge:
  1. enable_i=0 -> DISABLED, count=TIMEOUT.
  2. kick_i=1 -> count=TIMEOUT. This applies even when count==0, so kick wins over expiry.
  3. count==0 -> FIRING, pulse counter=PULSE_LEN-1, nreset_req_o=0.
  4. otherwise count=count-1.
- Expiry timing: ARMED is entered at edge E with count=TIMEOUT. With no kick, count reaches 0 at E+TIMEOUT. nreset_req_o falls at E+TIMEOUT+1.
- FIRING:
  - nreset_req_o is held 0 for exactly PULSE_LEN cycles.
  - kick_i and enable_i are ignored.
  - The pulse counter decrements each edge. When it reaches 0: nreset_req_o=1, count=TIMEOUT, next state = ARMED if enable_i=1, else DISABLED.
  - count_o holds 0 throughout FIRING.
- warn_o = (state==ARMED) && (count <= WARN). It is 0 in DISABLED and FIRING.
- Fire statistics, updated on the edge that enters FIRING:
  - fired_o is set to 1.
  - fire_count_o increments, saturating at 255.
- cause_clr_i:
  - On its own, clears fired_o and fire_count_o.
  - If it coincides with a FIRING entry, the set wins: fired_o=1, fire_count_o=1.
- Asserting reset_i mid-pulse immediately returns nreset_req_o to 1. Fire statistics are lost, so the block must sit in an always-on reset domain.
- The block has no dependency on its own nreset_req_o, so no combinational or reset loop is formed.
- Arithmetic: count is an unsigned CNT_W-bit value and never wraps below 0. The pulse counter is 8 bits.

Test Plan:
1. TIMEOUT=10, PULSE_LEN=4. Release reset, raise enable_i at edge 0, never kick -> nreset_req_o is low during edges 11..14 and high again at edge 15. fired_o=1, fire_count_o=1.
2. Kick every 8 cycles for 200 cycles -> nreset_req_o never goes low, fired_o stays 0, and count_o never drops below 2.
3. WARN=3. Armed, no kick -> warn_o rises when count_o=3 and falls on FIRING entry. A kick at count_o=0 reloads the count to 10 and no fire occurs.
4. Drop enable_i while count_o=5 -> DISABLED, count_o=10, no pulse. Drop enable_i during FIRING -> the pulse still lasts the full 4 cycles, then the state is DISABLED.
5. Let it fire 257 times -> fire_count_o=255. Assert cause_clr_i on the edge that enters FIRING -> fired_o=1, fire_count_o=1. A plain cause_clr_i then gives 0/0.
6. Assert reset_i asynchronously in the middle of a pulse -> nreset_req_o=1 immediately, all outputs take their reset values, and the state is DISABLED.

Source files
------------

// File: rtl/watchdog_reset.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : watchdog_reset                                                |
// | Purpose  : kickable watchdog driving a fixed-length active-low reset     |
// |            request, with sticky fire cause and saturating fire count.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module watchdog_reset #(
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 50000,
   parameter int WARN      = 1000,
   parameter int PULSE_LEN = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             kick_i,
   input  logic             cause_clr_i,
   output logic             nreset_req_o,
   output logic             warn_o,
   output logic             fired_o,
   output logic [7:0]       fire_count_o,
   output logic [CNT_W-1:0] count_o
);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FIRING   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_warn       = CNT_W'(WARN);
   localparam logic [7:0]       c_pulse_last = 8'(PULSE_LEN - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [7:0]       r_pulse_cnt;
   logic             r_nreset_req;
   logic             r_fired;
   logic [7:0]       r_fire_count;
   logic             w_fire_entry;

   // Kick outranks expiry, so a kick landing on count==0 never fires.
   assign w_fire_entry = (r_state == ST_ARMED) && enable_i && !kick_i &&
                         (r_count == '0);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state      <= ST_DISABLED;
         r_count      <= c_timeout;
         r_pulse_cnt  <= 8'd0;
         r_nreset_req <= 1'b1;
      end else begin
         case (r_state)
            ST_DISABLED: begin
               r_count <= c_timeout;
               if (enable_i) r_state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (!enable_i) begin
                  r_state <= ST_DISABLED;
                  r_count <= c_timeout;
               end else if (kick_i) begin
                  r_count <= c_timeout;
               end else if (r_count == '0) begin
                  r_state      <= ST_FIRING;
                  r_pulse_cnt  <= c_pulse_last;
                  r_nreset_req <= 1'b0;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            ST_FIRING: begin
               // Pulse length is fixed: kick and enable are only sampled at the end.
               if (r_pulse_cnt == 8'd0) begin
                  r_nreset_req <= 1'b1;
                  r_count      <= c_timeout;
                  r_state      <= enable_i ? ST_ARMED : ST_DISABLED;
               end else begin
                  r_pulse_cnt <= r_pulse_cnt - 8'd1;
               end
            end
            default: begin
               r_state      <= ST_DISABLED;
               r_count      <= c_timeout;
               r_nreset_req <= 1'b1;
            end
         endcase
      end
   end

   // A fire coinciding with a clear restarts the statistics at one fire.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_fired      <= 1'b0;
         r_fire_count <= 8'd0;
      end else if (w_fire_entry) begin
         r_fired <= 1'b1;
         if (cause_clr_i)
            r_fire_count <= 8'd1;
         else if (r_fire_count != 8'hFF)
            r_fire_count <= r_fire_count + 8'd1;
      end else if (cause_clr_i) begin
         r_fired      <= 1'b0;
         r_fire_count <= 8'd0;
      end
   end

   assign nreset_req_o = r_nreset_req;
   assign fired_o      = r_fired;
   assign fire_count_o = r_fire_count;
   assign count_o      = r_count;
   assign warn_o       = (r_state == ST_ARMED) && (r_count <= c_warn);

endmodule
`default_nettype wire

// File: tb/tb_watchdog_reset.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_watchdog_reset                                             |
// | Purpose  : scoreboard bench for watchdog_reset (TIMEOUT=10, PULSE_LEN=4) |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_watchdog_reset;

   localparam int c_cnt_w = 16;
   localparam int c_t     = 10;
   localparam int c_w     = 3;
   localparam int c_p     = 4;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              enable_i;
   logic              kick_i;
   logic              cause_clr_i;
   logic              nreset_req_o;
   logic              warn_o;
   logic              fired_o;
   logic [7:0]        fire_count_o;
   logic [c_cnt_w-1:0] count_o;

   watchdog_reset #(
      .CNT_W(c_cnt_w), .TIMEOUT(c_t), .WARN(c_w), .PULSE_LEN(c_p)
   ) u_dut (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .kick_i(kick_i),
      .cause_clr_i(cause_clr_i), .nreset_req_o(nreset_req_o), .warn_o(warn_o),
      .fired_o(fired_o), .fire_count_o(fire_count_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int nreq;
      int warn;
      int fired;
      int fcount;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model: 0 disabled, 1 armed, 2 firing; low_left counts remaining low cycles
   int m_st = 0, m_cnt = c_t, m_low_left = 0, m_fired = 0, m_fc = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_cnt = c_t; m_low_left = 0; m_fired = 0; m_fc = 0;
   endtask

   task automatic model_step(input logic en, input logic kick, input logic clr);
      bit fire = 0;
      case (m_st)
         0: begin m_cnt = c_t; if (en) m_st = 1; end
         1: begin
            if (!en) begin m_st = 0; m_cnt = c_t; end
            else if (kick) m_cnt = c_t;
            else if (m_cnt == 0) begin m_st = 2; m_low_left = c_p; fire = 1; end
            else m_cnt = m_cnt - 1;
         end
         default: begin
            m_low_left = m_low_left - 1;
            if (m_low_left == 0) begin m_st = en ? 1 : 0; m_cnt = c_t; end
         end
      endcase
      if (fire) begin
         m_fired = 1;
         m_fc = clr ? 1 : ((m_fc == 255) ? 255 : m_fc + 1);
      end else if (clr) begin
         m_fired = 0; m_fc = 0;
      end
   endtask

   // drive one cycle: push model expectation, then compare DUT after the edge
   task automatic cycle(input logic en, input logic kick, input logic clr);
      exp_t e;
      enable_i = en; kick_i = kick; cause_clr_i = clr;
      model_step(en, kick, clr);
      e.nreq = (m_st == 2) ? 0 : 1;
      e.warn = (m_st == 1 && m_cnt <= c_w) ? 1 : 0;
      e.fired = m_fired; e.fcount = m_fc; e.cnt = (m_st == 2) ? 0 : m_cnt;
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      check("nreq", int'(nreset_req_o), e.nreq);
      check("warn", int'(warn_o), e.warn);
      check("fired", int'(fired_o), e.fired);
      check("fcount", int'(fire_count_o), e.fcount);
      check("count", int'(count_o), e.cnt);
      @(negedge clk_i);
   endtask

   task automatic run_to_zero();
      for (int i = 0; i < 40 && !(m_st == 1 && m_cnt == 0); i++) cycle(1'b1, 1'b0, 1'b0);
      check("reach_zero", (m_st == 1 && m_cnt == 0) ? 1 : 0, 1);
   endtask

   task automatic fire_once(input logic clr);
      run_to_zero();
      cycle(1'b1, 1'b0, clr);
      for (int i = 1; i < c_p; i++) cycle(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int first_low, n_low, min_cnt, rise_cnt;
      logic prev_warn;
      reset_i = 1'b1; enable_i = 1'b0; kick_i = 1'b0; cause_clr_i = 1'b0;
      #2;
      check("rst_nreq", int'(nreset_req_o), 1);
      check("rst_warn", int'(warn_o), 0);
      check("rst_fired", int'(fired_o), 0);
      check("rst_fcount", int'(fire_count_o), 0);
      check("rst_count", int'(count_o), c_t);
      @(negedge clk_i);
      reset_i = 1'b0;
      model_reset();

      // expiry timing: enable at edge 0, low during edges 11..14
      first_low = -1; n_low = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (!nreset_req_o) begin
            n_low++;
            if (first_low < 0) first_low = k;
         end
      end
      check("t1_first_low_edge", first_low, 11);
      check("t1_low_cycles", n_low, 4);
      check("t1_fired", int'(fired_o), 1);
      check("t1_fcount", int'(fire_count_o), 1);
      cycle(1'b1, 1'b0, 1'b1);

      // periodic kicks keep it alive
      min_cnt = 1 << 20; n_low = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, (i % 8 == 0), 1'b0);
         if (int'(count_o) < min_cnt) min_cnt = int'(count_o);
         if (!nreset_req_o) n_low++;
      end
      check("t2_min_count_ge2", (min_cnt >= 2) ? 1 : 0, 1);
      check("t2_no_pulse", n_low, 0);
      check("t2_fired", int'(fired_o), 0);

      // warning threshold and kick at count 0
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      rise_cnt = -1; prev_warn = warn_o;
      for (int i = 0; i < 40 && !(m_st == 1 && m_cnt == 0); i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (warn_o && !prev_warn) rise_cnt = int'(count_o);
         prev_warn = warn_o;
      end
      check("t3_warn_rise_count", rise_cnt, 3);
      cycle(1'b1, 1'b1, 1'b0);
      check("t3_kick_at_zero", int'(count_o), 10);
      check("t3_no_fire", int'(fired_o), 0);
      run_to_zero();
      check("t3_warn_at_zero", int'(warn_o), 1);
      cycle(1'b1, 1'b0, 1'b0);
      check("t3_warn_fall_on_fire", int'(warn_o), 0);
      for (int i = 1; i < c_p; i++) cycle(1'b1, 1'b0, 1'b0);

      // enable dropped while armed, then while firing
      for (int i = 0; i < 20 && !(m_st == 1 && m_cnt == 5); i++) cycle(1'b1, 1'b0, 1'b0);
      check("t4_count5", int'(count_o), 5);
      cycle(1'b0, 1'b0, 1'b0);
      check("t4_disabled_count", int'(count_o), 10);
      n_low = 0;
      for (int i = 0; i < 15; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (!nreset_req_o) n_low++;
      end
      check("t4_no_pulse_disabled", n_low, 0);
      cycle(1'b1, 1'b0, 1'b0);
      run_to_zero();
      cycle(1'b1, 1'b0, 1'b0);
      n_low = nreset_req_o ? 0 : 1;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (!nreset_req_o) n_low++;
      end
      check("t4_full_pulse", n_low, 4);
      check("t4_held_disabled", int'(count_o), 10);

      // saturation and clear/fire collision
      cycle(1'b1, 1'b0, 1'b1);
      for (int f = 0; f < 257; f++) fire_once(1'b0);
      check("t5_sat_fcount", int'(fire_count_o), 255);
      check("t5_sat_fired", int'(fired_o), 1);
      run_to_zero();
      cycle(1'b1, 1'b0, 1'b1);
      check("t5_clr_on_fire_fired", int'(fired_o), 1);
      check("t5_clr_on_fire_fcount", int'(fire_count_o), 1);
      for (int i = 1; i < c_p; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      check("t5_clr_fired", int'(fired_o), 0);
      check("t5_clr_fcount", int'(fire_count_o), 0);

      // asynchronous reset mid-pulse
      run_to_zero();
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check("t6_in_pulse", int'(nreset_req_o), 0);
      reset_i = 1'b1;
      #1;
      check("t6_nreq", int'(nreset_req_o), 1);
      check("t6_fired", int'(fired_o), 0);
      check("t6_fcount", int'(fire_count_o), 0);
      check("t6_count", int'(count_o), c_t);
      check("t6_warn", int'(warn_o), 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      model_reset();
      cycle(1'b0, 1'b0, 1'b0);
      check("t6_disabled_hold", int'(count_o), c_t);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check("t6_rearm_count", int'(count_o), c_t - 1);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
